framebuffer_arb: RTL and testbench
==================================

FRAMEBUFFER_ARB -- requirements
Module: framebuffer_arb

Interface
REQ-001 SHALL have parameter FB_WORDS, default 384, meaning number of 32-bit words (48 rows x 8 words, 8 x 4-bit pixels per word).
REQ-002 SHALL have parameter WQ_DEPTH, default 2, meaning write-queue entries.
REQ-003 clk_25  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 rd_addr  input  9  video read word address.
REQ-006 rd_pix_sel  input  3  pixel-within-word select.
REQ-007 rd_pixel  output  4  selected pixel, combinational.
REQ-008 mem_read  input  1  video fetch in progress; memory reserved for reads this cycle.
REQ-009 wr_valid  input  1  host pixel-write request.
REQ-010 wr_ready  output  1  write queue can accept.
REQ-011 wr_x  input  6  pixel column 0..63.
REQ-012 wr_y  input  6  pixel row 0..47.
REQ-013 wr_pixel  input  4  pixel value.
REQ-014 wr_oob  output  1  sticky: out-of-range write dropped.
REQ-015 clr_req  input  1  single-cycle request to fill whole frame.
REQ-016 clr_colour  input  4  fill value, sampled with clr_req.
REQ-017 clr_busy  output  1  clear pending or in progress.

Function
REQ-018 Pixel index mapping: word = {y, x[5:3]}, lane = x[2:0], lane n at bits [4n+3:4n].
REQ-019 rd_pixel SHALL equal lane rd_pix_sel of word rd_addr same cycle; rd_addr >= FB_WORDS returns 4'h0.
REQ-020 Write accepted on edge where wr_valid && wr_ready; entry {x,y,pixel} pushed to FIFO queue.
REQ-021 wr_ready = queue not full && !clr_busy.
REQ-022 Entry with wr_y >= 48 SHALL be accepted, never written, and set wr_oob until reset.
REQ-023 Head entry commits (single nibble, other 7 lanes unchanged) on an edge where queue non-empty, mem_read == 0, state IDLE; one commit per cycle.
REQ-024 While mem_read == 1 no memory write of any kind occurs; pending work stalls, no data lost.
REQ-025 Simultaneous push and commit on full queue not possible (wr_ready low); on non-full queue both occur, occupancy unchanged.
REQ-026 rd_pixel reflects a commit from the edge after commit onward; same-cycle read returns old value.
REQ-027 States IDLE, CLR_WAIT, CLEAR.
REQ-028 IDLE -> CLR_WAIT on clr_req; clr_colour latched; clr_busy = 1 next cycle.
REQ-029 CLR_WAIT -> CLEAR when queue empty (queued writes drain first).
REQ-030 CLEAR writes clr_colour into all 8 lanes of word counter 0..FB_WORDS-1, one word per cycle with mem_read == 0; counter holds when mem_read == 1.
REQ-031 CLEAR -> IDLE after word FB_WORDS-1 written; clr_busy low from that edge; total 384 cycles with no stalls.
REQ-032 clr_req while CLR_WAIT or CLEAR SHALL be ignored (colour not re-latched).

Reset
REQ-033 rst_n low SHALL immediately force: state IDLE, queue empty, clear counter 0, wr_ready 1 (once released), wr_oob 0, clr_busy 0.
REQ-034 Memory array SHALL NOT be reset; contents undefined until written or cleared.
REQ-035 Reset mid-CLEAR SHALL abort; words already written keep clr_colour, rest unchanged.

Configuration
REQ-036 Macro FB_CLEAR_EN: defined -> clear engine present per REQ-027..032; undefined -> CLR_WAIT/CLEAR absent, clr_req/clr_colour ignored, clr_busy tied 0, ports retained.

Verification
REQ-037 Write x=10,y=5,pixel=0xA with mem_read=0 -> next cycle rd_addr=41,rd_pix_sel=2 returns 0xA; other lanes of word 41 unchanged.
REQ-038 Push 2 writes while mem_read=1 held 5 cycles -> wr_ready=0 after second, both commit in 2 cycles after mem_read falls.
REQ-039 Write y=48 -> no word changes, wr_oob=1 until rst_n low.
REQ-040 clr_req colour 0x3 with 1 queued write -> write commits first, then 384 cycles later clr_busy=0, every word 0x33333333.
REQ-041 mem_read pulsed 1-in-4 during CLEAR -> clear completes in 512 cycles; rd_addr=383 returns colour.
REQ-042 rst_n low at clear word 100 -> clr_busy=0 immediately; words 0..99 cleared, word 100+ unchanged.

Source files
------------

// File: rtl/framebuffer_arb_if.sv
// Signal bundle between the framebuffer arbiter and its clients:
// video read port, host pixel-write port and frame-clear request.
interface framebuffer_arb_if;
   logic [8:0] rd_addr;
   logic [2:0] rd_pix_sel;
   logic [3:0] rd_pixel;
   logic       mem_read;
   logic       wr_valid;
   logic       wr_ready;
   logic [5:0] wr_x;
   logic [5:0] wr_y;
   logic [3:0] wr_pixel;
   logic       wr_oob;
   logic       clr_req;
   logic [3:0] clr_colour;
   logic       clr_busy;

   modport master (
      output rd_addr, rd_pix_sel, mem_read, wr_valid, wr_x, wr_y, wr_pixel, clr_req, clr_colour,
      input  rd_pixel, wr_ready, wr_oob, clr_busy
   );

   modport slave (
      input  rd_addr, rd_pix_sel, mem_read, wr_valid, wr_x, wr_y, wr_pixel, clr_req, clr_colour,
      output rd_pixel, wr_ready, wr_oob, clr_busy
   );
endinterface

// File: rtl/framebuffer_arb.sv
// 4-bit-per-pixel framebuffer: host writes queue up and yield to video fetch.
// Define FB_CLEAR_EN to include the whole-frame clear engine.
module framebuffer_arb #(
   parameter int FB_WORDS = 384,
   parameter int WQ_DEPTH = 2
) (
   input  logic             clk_25,
   input  logic             rst_n,
   framebuffer_arb_if.slave fb
);
   localparam int QPW = (WQ_DEPTH > 1) ? $clog2(WQ_DEPTH) : 1;
   localparam int QCW = $clog2(WQ_DEPTH + 1);

   typedef struct packed {
      logic [5:0] x;
      logic [5:0] y;
      logic [3:0] pixel;
   } wq_entry_t;

   logic [31:0]    mem_r [FB_WORDS];
   wq_entry_t      wq_r  [WQ_DEPTH];
   logic [QPW-1:0] wr_ptr_r;
   logic [QPW-1:0] rd_ptr_r;
   logic [QCW-1:0] q_count_r;
   logic           wr_oob_r;
   logic           q_empty_s;
   logic           q_full_s;
   logic           wr_ready_s;
   logic           push_s;
   logic           commit_s;
   logic           mem_wr_s;
   logic           busy_s;
   logic           clear_phase_s;
   logic           clr_wr_s;
   logic [8:0]     clr_addr_s;
   logic [31:0]    clr_fill_s;
   logic [8:0]     commit_addr_s;
   logic [31:0]    rd_word_s;
   wq_entry_t      head_s;

   function automatic logic [QPW-1:0] ptr_inc(input logic [QPW-1:0] p);
      if (p == QPW'(WQ_DEPTH - 1)) begin
         return {QPW{1'b0}};
      end else begin
         return p + QPW'(1);
      end
   endfunction

   assign q_empty_s     = (q_count_r == {QCW{1'b0}});
   assign q_full_s      = (q_count_r == QCW'(WQ_DEPTH));
   assign wr_ready_s    = !q_full_s && !busy_s;
   assign push_s        = fb.wr_valid && wr_ready_s;
   assign head_s        = wq_r[rd_ptr_r];
   assign commit_addr_s = {head_s.y, head_s.x[5:3]};
   // The clear engine owns the memory in CLEAR; queued writes may still drain while waiting for it.
   assign commit_s      = !q_empty_s && !fb.mem_read && !clear_phase_s;
   assign mem_wr_s      = commit_s && (head_s.y < 6'd48) && (int'(commit_addr_s) < FB_WORDS);

`ifdef FB_CLEAR_EN
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      CLR_WAIT = 2'd1,
      CLEAR    = 2'd2
   } state_t;

   state_t     state_r;
   state_t     state_nx_s;
   logic [8:0] clr_cnt_r;
   logic [8:0] clr_cnt_nx_s;
   logic [3:0] clr_colour_r;
   logic       latch_colour_s;

   // Clear engine next-state, word counter and write strobe
   always_comb begin
      state_nx_s     = state_r;
      clr_cnt_nx_s   = clr_cnt_r;
      clr_wr_s       = 1'b0;
      latch_colour_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (fb.clr_req) begin
               state_nx_s     = CLR_WAIT;
               latch_colour_s = 1'b1;
            end else begin
               state_nx_s = IDLE;
            end
         end
         CLR_WAIT: begin
            if (q_empty_s) begin
               state_nx_s = CLEAR;
            end else begin
               state_nx_s = CLR_WAIT;
            end
         end
         CLEAR: begin
            if (!fb.mem_read) begin
               clr_wr_s = 1'b1;
               if (clr_cnt_r == 9'(FB_WORDS - 1)) begin
                  state_nx_s   = IDLE;
                  clr_cnt_nx_s = 9'd0;
               end else begin
                  clr_cnt_nx_s = clr_cnt_r + 9'd1;
               end
            end else begin
               clr_cnt_nx_s = clr_cnt_r;
            end
         end
         default: begin
            state_nx_s   = IDLE;
            clr_cnt_nx_s = 9'd0;
         end
      endcase
   end

   // Clear engine state, counter and latched fill colour
   always_ff @(posedge clk_25 or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= IDLE;
         clr_cnt_r    <= 9'd0;
         clr_colour_r <= 4'h0;
      end else begin
         state_r   <= state_nx_s;
         clr_cnt_r <= clr_cnt_nx_s;
         if (latch_colour_s) begin
            clr_colour_r <= fb.clr_colour;
         end
      end
   end

   assign busy_s        = (state_r != IDLE);
   assign clear_phase_s = (state_r == CLEAR);
   assign clr_addr_s    = clr_cnt_r;
   assign clr_fill_s    = {8{clr_colour_r}};
`else
   logic unused_clr_s;

   assign unused_clr_s  = ^{fb.clr_req, fb.clr_colour};
   assign busy_s        = 1'b0;
   assign clear_phase_s = 1'b0;
   assign clr_wr_s      = 1'b0;
   assign clr_addr_s    = 9'd0;
   assign clr_fill_s    = 32'h0;
`endif

   // Write-queue pointers, occupancy and sticky out-of-range flag
   always_ff @(posedge clk_25 or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r  <= {QPW{1'b0}};
         rd_ptr_r  <= {QPW{1'b0}};
         q_count_r <= {QCW{1'b0}};
         wr_oob_r  <= 1'b0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= ptr_inc(wr_ptr_r);
         end
         if (commit_s) begin
            rd_ptr_r <= ptr_inc(rd_ptr_r);
         end
         case ({push_s, commit_s})
            2'b10:   q_count_r <= q_count_r + QCW'(1);
            2'b01:   q_count_r <= q_count_r - QCW'(1);
            default: q_count_r <= q_count_r;
         endcase
         if (push_s && (fb.wr_y >= 6'd48)) begin
            wr_oob_r <= 1'b1;
         end
      end
   end

   // Queue storage; entries are only read after being pushed, so no reset
   always_ff @(posedge clk_25) begin
      if (push_s) begin
         wq_r[wr_ptr_r] <= {fb.wr_x, fb.wr_y, fb.wr_pixel};
      end
   end

   // Frame memory: clear fills whole words, a commit replaces one nibble
   always_ff @(posedge clk_25) begin
      if (clr_wr_s) begin
         mem_r[clr_addr_s] <= clr_fill_s;
      end else if (mem_wr_s) begin
         mem_r[commit_addr_s][{head_s.x[2:0], 2'b00} +: 4] <= head_s.pixel;
      end
   end

   // Video read word, zero beyond the frame
   always_comb begin
      rd_word_s = 32'h0;
      if (int'(fb.rd_addr) < FB_WORDS) begin
         rd_word_s = mem_r[fb.rd_addr];
      end else begin
         rd_word_s = 32'h0;
      end
   end

   assign fb.rd_pixel = rd_word_s[{fb.rd_pix_sel, 2'b00} +: 4];
   assign fb.wr_ready = wr_ready_s;
   assign fb.wr_oob   = wr_oob_r;
   assign fb.clr_busy = busy_s;
endmodule

// File: tb/tb_framebuffer_arb.sv
// Randomised bench for framebuffer_arb against a pixel-level model with a FIFO write queue.
module tb_framebuffer_arb;
   localparam int FB_WORDS = 384;
   localparam int WQ_DEPTH = 2;

   logic clk_25 = 1'b0;
   logic rst_n  = 1'b0;

   framebuffer_arb_if bus ();

   framebuffer_arb #(.FB_WORDS(FB_WORDS), .WQ_DEPTH(WQ_DEPTH)) dut (
      .clk_25 (clk_25),
      .rst_n  (rst_n),
      .fb     (bus)
   );

   always #20 clk_25 = ~clk_25;

   typedef struct {
      int x;
      int y;
      int p;
   } wr_t;

   logic [3:0] m_pix   [48][64];
   bit         m_known [48][64];
   wr_t        m_q     [$];
   bit         m_oob    = 1'b0;
   int         m_state  = 0;   // 0 idle, 1 waiting for queue, 2 clearing
   int         m_cnt    = 0;
   int         m_colour = 0;
   int         errors   = 0;
   int         checks   = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic timeout_fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: wait bound expired at %0t", name, $time);
   endtask

   function automatic bit model_ready();
      return (m_q.size() < WQ_DEPTH) && (m_state == 0);
   endfunction

   // Expected rd_pixel from the pixel array, -1 when the pixel was never written
   function automatic int model_rd();
      int word;
      int x;
      int y;
      word = int'(bus.rd_addr);
      if (word >= FB_WORDS) return 0;
      y = word / 8;
      x = (word % 8) * 8 + int'(bus.rd_pix_sel);
      if (!m_known[y][x]) return -1;
      return int'(m_pix[y][x]);
   endfunction

   task automatic check_outputs();
      int e;
      chk("wr_ready", int'(bus.wr_ready), int'(model_ready()));
      chk("wr_oob", int'(bus.wr_oob), int'(m_oob));
      chk("clr_busy", int'(bus.clr_busy), (m_state != 0) ? 1 : 0);
      e = model_rd();
      if (e >= 0) chk("rd_pixel", int'(bus.rd_pixel), e);
   endtask

   // Effect of one rising edge, from the inputs presented before it
   task automatic model_step();
      int  qsize_pre;
      bit  ready;
      bit  commit;
      wr_t e;
      qsize_pre = m_q.size();
      ready     = model_ready();
      commit    = (qsize_pre > 0) && !bus.mem_read && (m_state != 2);
      if (commit) begin
         e = m_q.pop_front();
         if (e.y < 48) begin
            m_pix[e.y][e.x]   = 4'(e.p);
            m_known[e.y][e.x] = 1'b1;
         end
      end
      if (bus.wr_valid && ready) begin
         e.x = int'(bus.wr_x);
         e.y = int'(bus.wr_y);
         e.p = int'(bus.wr_pixel);
         m_q.push_back(e);
         if (e.y >= 48) m_oob = 1'b1;
      end
`ifdef FB_CLEAR_EN
      case (m_state)
         0: if (bus.clr_req) begin
               m_state  = 1;
               m_colour = int'(bus.clr_colour);
            end
         1: if (qsize_pre == 0) m_state = 2;
         default: if (!bus.mem_read) begin
               for (int i = 0; i < 8; i++) begin
                  m_pix[m_cnt / 8][(m_cnt % 8) * 8 + i]   = 4'(m_colour);
                  m_known[m_cnt / 8][(m_cnt % 8) * 8 + i] = 1'b1;
               end
               m_cnt++;
               if (m_cnt == FB_WORDS) begin
                  m_cnt   = 0;
                  m_state = 0;
               end
            end
      endcase
`endif
   endtask

   // Called at a falling edge with inputs already set
   task automatic cycle();
      #1 check_outputs();
      @(posedge clk_25);
      model_step();
      @(negedge clk_25);
   endtask

   task automatic write_px(input int x, input int y, input int p);
      int guard;
      guard        = 0;
      bus.wr_x     = 6'(x);
      bus.wr_y     = 6'(y);
      bus.wr_pixel = 4'(p);
      bus.wr_valid = 1'b1;
      while (!model_ready() && guard < 50) begin
         cycle();
         guard++;
      end
      if (guard >= 50) timeout_fail("write_accept");
      cycle();
      bus.wr_valid = 1'b0;
   endtask

   task automatic do_reset();
      #3 rst_n = 1'b0;
      #1;
      m_q.delete();
      m_oob   = 1'b0;
      m_state = 0;
      m_cnt   = 0;
      chk("rst_wr_oob", int'(bus.wr_oob), 0);
      chk("rst_clr_busy", int'(bus.clr_busy), 0);
      chk("rst_wr_ready", int'(bus.wr_ready), 1);
      @(negedge clk_25);
      rst_n = 1'b1;
   endtask

   initial begin
      int n;
      bus.rd_addr    = 9'd0;
      bus.rd_pix_sel = 3'd0;
      bus.mem_read   = 1'b0;
      bus.wr_valid   = 1'b0;
      bus.wr_x       = 6'd0;
      bus.wr_y       = 6'd0;
      bus.wr_pixel   = 4'h0;
      bus.clr_req    = 1'b0;
      bus.clr_colour = 4'h0;
      #1;
      chk("reset_wr_ready", int'(bus.wr_ready), 1);
      chk("reset_wr_oob", int'(bus.wr_oob), 0);
      chk("reset_clr_busy", int'(bus.clr_busy), 0);
      repeat (2) @(negedge clk_25);
      rst_n = 1'b1;

      // Single-nibble write into word 41 lane 2, neighbours preserved
      bus.rd_addr    = 9'd41;
      bus.rd_pix_sel = 3'd2;
      for (int i = 0; i < 8; i++) write_px(8 + i, 5, i + 1);
      write_px(10, 5, 'hA);
      chk("same_cycle_old", int'(bus.rd_pixel), 'h3);
      cycle();
      chk("w41_lane2", int'(bus.rd_pixel), 'hA);
      bus.rd_pix_sel = 3'd1;
      #1 chk("w41_lane1", int'(bus.rd_pixel), 'h2);
      bus.rd_pix_sel = 3'd3;
      #1 chk("w41_lane3", int'(bus.rd_pixel), 'h4);

      // Writes stall while video holds the memory
      bus.rd_addr    = 9'd0;
      bus.rd_pix_sel = 3'd0;
      write_px(0, 0, 'hF);
      write_px(1, 0, 'hF);
      cycle();
      bus.mem_read = 1'b1;
      write_px(0, 0, 'h5);
      write_px(1, 0, 'h6);
      chk("stall_full_ready", int'(bus.wr_ready), 0);
      repeat (3) cycle();
      chk("stall_no_write", int'(bus.rd_pixel), 'hF);
      bus.mem_read = 1'b0;
      cycle();
      cycle();
      chk("drain_ready", int'(bus.wr_ready), 1);
      chk("drain_lane0", int'(bus.rd_pixel), 'h5);
      bus.rd_pix_sel = 3'd1;
      #1 chk("drain_lane1", int'(bus.rd_pixel), 'h6);

      // Out-of-range row is swallowed and flagged until reset
      bus.rd_pix_sel = 3'd3;
      write_px(3, 48, 'h9);
      cycle();
      chk("oob_flag", int'(bus.wr_oob), 1);
      bus.rd_pix_sel = 3'd0;
      #1 chk("oob_no_write", int'(bus.rd_pixel), 'h5);
      do_reset();

`ifdef FB_CLEAR_EN
      // Clear with one queued write: write drains first, then 384 word writes
      bus.mem_read = 1'b1;
      write_px(0, 1, 'h7);
      bus.mem_read   = 1'b0;
      bus.clr_req    = 1'b1;
      bus.clr_colour = 4'h3;
      cycle();
      bus.clr_req = 1'b0;
      n = 0;
      while (bus.clr_busy && n < 2000) begin
         cycle();
         n++;
      end
      chk("clear_cycles", n, 385);
      bus.rd_addr    = 9'd383;
      bus.rd_pix_sel = 3'd7;
      #1 chk("clear_last_word", int'(bus.rd_pixel), 'h3);
      bus.rd_addr    = 9'd8;
      bus.rd_pix_sel = 3'd0;
      #1 chk("clear_over_write", int'(bus.rd_pixel), 'h3);
      cycle();

      // Clear with video fetch on one cycle in four
      bus.clr_req    = 1'b1;
      bus.clr_colour = 4'hC;
      cycle();
      bus.clr_req = 1'b0;
      n = 0;
      while (bus.clr_busy && n < 2000) begin
         bus.mem_read = ((n % 4) == 3);
         cycle();
         n++;
      end
      bus.mem_read = 1'b0;
      chk("pulsed_clear_cycles", n, 513);
      bus.rd_addr = 9'd383;
      #1 chk("pulsed_last_word", int'(bus.rd_pixel), 'hC);
      cycle();

      // Reset part-way through a clear
      bus.clr_req    = 1'b1;
      bus.clr_colour = 4'h5;
      cycle();
      bus.clr_req = 1'b0;
      n = 0;
      while (m_cnt < 100 && n < 1000) begin
         cycle();
         n++;
      end
      if (n >= 1000) timeout_fail("clear_word_100");
      do_reset();
      bus.rd_addr = 9'd99;
      #1 chk("abort_word99", int'(bus.rd_pixel), 'h5);
      bus.rd_addr = 9'd100;
      #1 chk("abort_word100", int'(bus.rd_pixel), 'hC);
      cycle();
`endif

      // Randomised traffic
      for (int c = 0; c < 3000; c++) begin
         bus.wr_valid = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 1) == 0) begin
            bus.wr_x = 6'($urandom_range(0, 15));
            bus.wr_y = 6'($urandom_range(0, 7));
         end else begin
            bus.wr_x = 6'($urandom_range(0, 63));
            bus.wr_y = 6'($urandom_range(0, 50));
         end
         bus.wr_pixel = 4'($urandom_range(0, 15));
         bus.mem_read = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 1) == 0) bus.rd_addr = 9'($urandom_range(0, 63));
         else bus.rd_addr = 9'($urandom_range(0, 399));
         bus.rd_pix_sel = 3'($urandom_range(0, 7));
         bus.clr_req    = ($urandom_range(0, 499) == 0);
         bus.clr_colour = 4'($urandom_range(0, 15));
         cycle();
      end
      bus.wr_valid = 1'b0;
      bus.mem_read = 1'b0;
      bus.clr_req  = 1'b0;
      repeat (5) cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
